// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer block.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Sequencer states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Terminal behaviour captured at start.
  typedef enum logic {
    ONE_SHOT    = 1'b0,
    AUTO_RELOAD = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a requester and the counter sequencer.
// Handshake: the requester raises start for one or more cycles; the sequencer
// accepts it only on an edge where it is idle and stop is low, and answers with
// busy one cycle later. Completion is signalled by a single-cycle done pulse;
// stop aborts without done. There is no backpressure on done.
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             hold;
  logic             up_down;
  logic             mode;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] terminal_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, hold, up_down, mode, load_value, terminal_value,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, hold, up_down, mode, load_value, terminal_value,
    output count, busy, done
  );
endinterface

// File: rtl/counter_sequencer_core.sv
// Up/down counter datapath: synchronous load beats enable, wraps modulo 2^WIDTH.
module updown_counter_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load first, then a +/-1 step when enabled, else hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = up_down ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer FSM that runs the counter core through load -> count -> terminal,
// with one-shot / auto-reload, hold and abort. Parameters for a sequence are
// latched into shadow registers at start so the bus may change while busy.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clock_signal,
  input  logic                reset_signal,
  counter_sequencer_if.slave  bus,
  output state_e              state_dbg
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] load_sh_q, load_sh_d;
  logic [WIDTH-1:0] term_sh_q, term_sh_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             ctr_load;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_load_value;
  logic [WIDTH-1:0] count_w;

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clock_signal),
    .rst        (reset_signal),
    .load       (ctr_load),
    .enable     (ctr_enable),
    .up_down    (dir_q),
    .load_value (ctr_load_value),
    .count      (count_w)
  );

  // Next state, shadow capture and counter controls.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    mode_d         = mode_q;
    load_sh_d      = load_sh_q;
    term_sh_d      = term_sh_q;
    done_d         = 1'b0;
    ctr_load       = 1'b0;
    ctr_enable     = 1'b0;
    ctr_load_value = load_sh_q;

    case (state_q)
      IDLE: begin
        // stop overrides a simultaneous start; nothing is captured then.
        if (bus.start && !bus.stop) begin
          dir_d          = bus.up_down;
          mode_d         = mode_e'(bus.mode);
          load_sh_d      = bus.load_value;
          term_sh_d      = bus.terminal_value;
          ctr_load       = 1'b1;
          ctr_load_value = bus.load_value;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (count_w == term_sh_q) begin
          // Terminal wins over hold so a sequence never misses its done.
          done_d = 1'b1;
          if (mode_q == AUTO_RELOAD) begin
            ctr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.hold) begin
          state_d = HOLD;
        end else begin
          ctr_enable = 1'b1;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, shadow and status registers.
  always_ff @(posedge clock_signal or posedge reset_signal) begin
    if (reset_signal) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      mode_q    <= ONE_SHOT;
      load_sh_q <= '0;
      term_sh_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      load_sh_q <= load_sh_d;
      term_sh_q <= term_sh_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.count = count_w;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int W = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e state_dbg;
  int     tests_run = 0;
  int     tests_failed = 0;

  counter_sequencer_if #(.WIDTH(W)) cs_if ();

  counter_sequencer #(.WIDTH(W)) dut (
    .clock_signal (clk),
    .reset_signal (rst),
    .bus          (cs_if.slave),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] ld, input logic [W-1:0] term,
                             input logic dir, input logic md);
    cs_if.load_value     = ld;
    cs_if.terminal_value = term;
    cs_if.up_down        = dir;
    cs_if.mode           = md;
    cs_if.start          = 1'b1;
    tick();
    cs_if.start          = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (cs_if.count !== 4'd0 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL reset: count=%0d busy=%b done=%b state=%0d, want 0/0/0/IDLE",
               cs_if.count, cs_if.busy, cs_if.done, state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_one_shot_up();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    exp_q = '{4'd2, 4'd3, 4'd4, 4'd5};
    drive_start(4'd2, 4'd5, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      tests_run++;
      if (cs_if.count !== e || cs_if.busy !== 1'b1 || cs_if.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL one_shot_up step%0d: count=%0d busy=%b done=%b, want %0d/1/0",
                 k, cs_if.count, cs_if.busy, cs_if.done, e);
      end
    end
    tick();
    tests_run++;
    if (cs_if.count !== 4'd5 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b1 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL one_shot_up terminal: count=%0d busy=%b done=%b state=%0d, want 5/0/1/IDLE",
               cs_if.count, cs_if.busy, cs_if.done, state_dbg);
    end
    tick();
    tests_run++;
    if (cs_if.count !== 4'd5 || cs_if.done !== 1'b0 || cs_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_shot_up after: count=%0d done=%b busy=%b, want 5/0/0",
               cs_if.count, cs_if.done, cs_if.busy);
    end
  endtask

  task automatic test_auto_reload_down();
    logic [W-1:0] cnt_tab[10] = '{4'd1, 4'd0, 4'd15, 4'd14, 4'd1, 4'd0, 4'd15, 4'd14, 4'd1, 4'd0};
    logic         done_tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive_start(4'd1, 4'd14, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      tests_run++;
      if (cs_if.count !== cnt_tab[k] || cs_if.done !== done_tab[k] || cs_if.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL auto_reload_down step%0d: count=%0d done=%b busy=%b, want %0d/%b/1",
                 k, cs_if.count, cs_if.done, cs_if.busy, cnt_tab[k], done_tab[k]);
      end
    end
    cs_if.stop = 1'b1;
    tick();
    cs_if.stop = 1'b0;
    tests_run++;
    if (cs_if.count !== 4'd0 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL auto_reload_stop: count=%0d busy=%b done=%b, want 0/0/0",
               cs_if.count, cs_if.busy, cs_if.done);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] cnt_tab[8]  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3};
    logic         busy_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         done_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    state_e       st_tab[8]   = '{RUN, RUN, HOLD, HOLD, RUN, RUN, RUN, IDLE};
    drive_start(4'd0, 4'd3, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      tests_run++;
      if (cs_if.count !== cnt_tab[k] || cs_if.busy !== busy_tab[k] ||
          cs_if.done !== done_tab[k] || state_dbg !== st_tab[k]) begin
        tests_failed++;
        $display("FAIL hold step%0d: count=%0d busy=%b done=%b state=%0d, want %0d/%b/%b/%0d",
                 k, cs_if.count, cs_if.busy, cs_if.done, state_dbg,
                 cnt_tab[k], busy_tab[k], done_tab[k], st_tab[k]);
      end
      if (k == 1) cs_if.hold = 1'b1;
      if (k == 3) cs_if.hold = 1'b0;
    end
    // Hold arriving on the terminal edge must not suppress done.
    drive_start(4'd0, 4'd3, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    cs_if.hold = 1'b1;
    tick();
    cs_if.hold = 1'b0;
    tests_run++;
    if (cs_if.count !== 4'd3 || cs_if.done !== 1'b1 || cs_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_at_terminal: count=%0d done=%b busy=%b, want 3/1/0",
               cs_if.count, cs_if.done, cs_if.busy);
    end
    tick();
  endtask

  task automatic test_stop_start_collision();
    drive_start(4'd0, 4'd10, 1'b1, 1'b0);
    tick();
    tick();
    cs_if.stop = 1'b1;
    tick();
    cs_if.stop = 1'b0;
    tests_run++;
    if (cs_if.count !== 4'd2 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL stop_in_run: count=%0d busy=%b done=%b state=%0d, want 2/0/0/IDLE",
               cs_if.count, cs_if.busy, cs_if.done, state_dbg);
    end
    // start and stop together while idle: nothing happens.
    cs_if.stop = 1'b1;
    drive_start(4'd5, 4'd9, 1'b1, 1'b0);
    cs_if.stop = 1'b0;
    tests_run++;
    if (cs_if.count !== 4'd2 || cs_if.busy !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL start_with_stop: count=%0d busy=%b state=%0d, want 2/0/IDLE",
               cs_if.count, cs_if.busy, state_dbg);
    end
    // start while busy, with new bus values, must not disturb the sequence.
    drive_start(4'd3, 4'd4, 1'b1, 1'b0);
    tests_run++;
    if (cs_if.count !== 4'd3 || cs_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start launch: count=%0d busy=%b, want 3/1", cs_if.count, cs_if.busy);
    end
    drive_start(4'd12, 4'd0, 1'b0, 1'b1);
    tests_run++;
    if (cs_if.count !== 4'd4 || cs_if.busy !== 1'b1 || cs_if.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start ignored: count=%0d busy=%b done=%b, want 4/1/0",
               cs_if.count, cs_if.busy, cs_if.done);
    end
    tick();
    tests_run++;
    if (cs_if.count !== 4'd4 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start shadows: count=%0d busy=%b done=%b, want 4/0/1",
               cs_if.count, cs_if.busy, cs_if.done);
    end
    tick();
  endtask

  task automatic test_load_eq_term();
    drive_start(4'd7, 4'd7, 1'b1, 1'b1);
    tests_run++;
    if (cs_if.count !== 4'd7 || cs_if.done !== 1'b0 || cs_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_eq_term launch: count=%0d done=%b busy=%b, want 7/0/1",
               cs_if.count, cs_if.done, cs_if.busy);
    end
    for (int k = 1; k < 5; k++) begin
      tick();
      tests_run++;
      if (cs_if.count !== 4'd7 || cs_if.done !== 1'b1 || cs_if.busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_eq_term step%0d: count=%0d done=%b busy=%b, want 7/1/1",
                 k, cs_if.count, cs_if.done, cs_if.busy);
      end
    end
    cs_if.stop = 1'b1;
    tick();
    cs_if.stop = 1'b0;
    tests_run++;
    if (cs_if.done !== 1'b0 || cs_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_eq_term stop: done=%b busy=%b, want 0/0", cs_if.done, cs_if.busy);
    end
  endtask

  task automatic test_async_reset();
    drive_start(4'd0, 4'd15, 1'b1, 1'b0);
    tick();
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (cs_if.count !== 4'd0 || cs_if.busy !== 1'b0 || cs_if.done !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL async_reset: count=%0d busy=%b done=%b state=%0d, want 0/0/0/IDLE",
               cs_if.count, cs_if.busy, cs_if.done, state_dbg);
    end
    #2;
    rst = 1'b0;
    drive_start(4'd9, 4'd15, 1'b1, 1'b0);
    tests_run++;
    if (cs_if.count !== 4'd9 || cs_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_after_reset: count=%0d busy=%b, want 9/1", cs_if.count, cs_if.busy);
    end
    cs_if.stop = 1'b1;
    tick();
    cs_if.stop = 1'b0;
  endtask

  // Test sequence and final report.
  initial begin
    cs_if.start          = 1'b0;
    cs_if.stop           = 1'b0;
    cs_if.hold           = 1'b0;
    cs_if.up_down        = 1'b0;
    cs_if.mode           = 1'b0;
    cs_if.load_value     = '0;
    cs_if.terminal_value = '0;
    test_reset();
    test_one_shot_up();
    test_auto_reload_down();
    test_hold();
    test_stop_start_collision();
    test_load_eq_term();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Programmable interval controller that sequences an up/down binary counter through a load -> count -> terminal cycle. It supports one-shot and auto-reload modes, pause (hold) and abort (stop). It emits a one-cycle done pulse at terminal count. It sits above the counter datapath and gives the rest of the design a start/done handshake instead of raw toggle/reset control.

Parameters:
WIDTH, 4, counter width in bits; count arithmetic is modulo 2^WIDTH.

Ports:
clock_signal  input  1  single system clock, rising edge.
reset_signal  input  1  asynchronous, active-high reset.
start  input  1  request to begin a sequence; sampled only in IDLE.
stop  input  1  abort the running sequence; returns to IDLE without done.
hold  input  1  level; freezes counting while high in RUN.
up_down  input  1  direction, 1 = up, 0 = down; captured at start.
mode  input  1  0 = one-shot, 1 = auto-reload; captured at start.
load_value  input  WIDTH  initial count; captured at start.
terminal_value  input  WIDTH  terminal count; captured at start.
count  output  WIDTH  current counter value, registered.
busy  output  1  high when state is RUN or HOLD.
done  output  1  one-cycle registered pulse on terminal action.

Behaviour:
- States: IDLE, RUN, HOLD. Encoding is in the package.
- Reset (async, any time, including mid-sequence): state=IDLE, count=0, busy=0, done=0, shadow registers cleared.
- IDLE:
  - On an edge with start=1 and stop=0, capture up_down, mode, load_value and terminal_value into shadow registers.
  - On that same edge, count<=load_value and state<=RUN. Latency: count=load_value and busy=1 one cycle after start is sampled.
  - start=1 with stop=1 in IDLE: stop wins, start ignored, nothing captured.
  - While in IDLE, count keeps its last value.
- RUN, evaluated each edge in priority order:
  1. stop=1: state<=IDLE, count holds, done stays 0.
  2. count==terminal_shadow: terminal action.
     - One-shot: state<=IDLE, count holds terminal value, done<=1.
     - Auto-reload: count<=load_shadow, state stays RUN, done<=1.
  3. hold=1: state<=HOLD, count holds.
  4. Otherwise count<=count+1 (up) or count-1 (down), modulo 2^WIDTH, with wrap (all-ones <-> 0).
- Terminal takes priority over hold on the same edge.
- Period: the terminal action fires on the Nth edge after start, where N = ((terminal-load) mod 2^WIDTH)+1 for up, or ((load-terminal) mod 2^WIDTH)+1 for down.
- load==terminal: done on the first RUN edge, giving N=1.
- HOLD:
  - stop=1: go to IDLE, no done.
  - hold=0: go to RUN; counting resumes on the following edge.
  - No counting and no terminal check while in HOLD.
- start while busy: ignored. Input changes to up_down, mode, load_value or terminal_value while busy: no effect until the next start.
- done: high for exactly one cycle per terminal action and never in IDLE except the cycle right after a one-shot terminal action. Back-to-back done pulses in auto-reload only when N=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package counter_seq_pkg: state encoding constants (IDLE, RUN, HOLD), default WIDTH, mode encodings (ONE_SHOT=0, AUTO_RELOAD=1).
- Sub-module updown_counter_core: WIDTH-bit register with async active-high reset to 0.
  - Synchronous load takes priority over enable.
  - With enable and up_down it steps ±1 with wrap.
  - The sequencer drives its load, enable and up_down signals and holds the FSM and shadow registers.

Test Plan:
- One-shot up: load=2, term=5, up, mode=0, start pulse -> count 2,3,4,5 on consecutive cycles; done=1 for one cycle on the next edge with count=5; busy falls on the same edge.
- Auto-reload wrap down: load=1, term=14, down, mode=1 -> count 1,0,15,14,1,0,15,14…; done pulses every 4 cycles; busy stays high.
- Hold: load=0, term=3, up; assert hold for 3 cycles when count=1 -> count stays 1 for 3 cycles, then 2,3; done is delayed by exactly 3 cycles. Hold asserted on the edge where count=3 -> done still fires.
- Stop and start collisions:
  - stop when count=2 in RUN -> IDLE next edge, count=2, no done.
  - start+stop together in IDLE -> remains IDLE, busy=0.
  - start while busy -> ignored, shadows unchanged.
- Edge cases:
  - load=term=7, mode=1 -> done high every cycle, count=7 constant.
  - Async reset asserted mid-RUN between edges -> count=0, busy=0, done=0 immediately.
  - After release, start with load=9 -> count=9 next cycle.
